// File: rtl/gpr_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module : gpr_pkg                                                        |
// | Shared constants and write-winner helper for the multi-port GPR file.   |
// | Rev    : 1.0  initial release                                           |
// +-------------------------------------------------------------------------+
package gpr_pkg;

   localparam int ZERO_REG   = 0;
   localparam int GPR_DATA_W = 32;
   localparam int GPR_ADDR_W = 5;

   // Write-port count the helper can arbitrate; NWR must not exceed it.
   localparam int MAX_WR     = 16;
   localparam int WR_IDX_W   = 4;

   // Highest set bit of the per-port match vector wins; -1 when nothing matches.
   function automatic int wr_winner(input logic [MAX_WR-1:0] match);
      int win;
      win = -1;
      for (int p = 0; p < MAX_WR; p++) begin
         if (match[p]) win = p;
      end
      return win;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gpr_scoreboard.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module : gpr_scoreboard                                                 |
// | Per-register outstanding-write counters, issue back-pressure, source    |
// | stalls and writeback-without-issue error pulse.                         |
// | Rev    : 1.0  initial release                                           |
// +-------------------------------------------------------------------------+
module gpr_scoreboard
   import gpr_pkg::*;
#(
   parameter int ADDR_W = GPR_ADDR_W,
   parameter int NRD    = 2,
   parameter int NWR    = 2,
   parameter int CNT_W  = 2
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NRD-1:0]        rd_en,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   input  logic [NWR-1:0]        wr_en,
   input  logic [NWR*ADDR_W-1:0] wr_addr,
   input  logic                  iss_valid,
   input  logic [ADDR_W-1:0]     iss_addr,
   output logic                  iss_ready,
   output logic [NRD-1:0]        rd_stall,
   output logic                  sb_err
);

   localparam int               c_depth   = 2**ADDR_W;
   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   logic [CNT_W-1:0] r_cnt     [c_depth];
   logic [CNT_W-1:0] w_cnt_nxt [c_depth];
   logic [c_depth-1:0] w_wr_hit;
   logic               w_err_nxt;
   logic               r_sb_err;

   always_comb begin : p_cnt_next
      logic [MAX_WR-1:0] v_match;
      logic              v_inc;
      logic              v_dec;
      v_match   = '0;
      v_inc     = 1'b0;
      v_dec     = 1'b0;
      w_wr_hit  = '0;
      w_err_nxt = 1'b0;
      for (int a = 0; a < c_depth; a++) w_cnt_nxt[a] = r_cnt[a];
      for (int a = 1; a < c_depth; a++) begin
         v_match = '0;
         for (int p = 0; p < NWR; p++)
            v_match[p] = wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(a));
         // Several ports hitting one register retire a single outstanding write.
         w_wr_hit[a] = reset && (wr_winner(v_match) >= 0);
         v_inc = iss_valid && (iss_addr == ADDR_W'(a)) && (r_cnt[a] != c_cnt_max);
         v_dec = w_wr_hit[a] && (r_cnt[a] != '0);
         if (v_inc && !v_dec)
            w_cnt_nxt[a] = r_cnt[a] + 1'b1;
         else if (v_dec && !v_inc)
            w_cnt_nxt[a] = r_cnt[a] - 1'b1;
         if (w_wr_hit[a] && (r_cnt[a] == '0)) w_err_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int a = 0; a < c_depth; a++) r_cnt[a] <= '0;
         r_sb_err <= 1'b0;
      end else begin
         for (int a = 0; a < c_depth; a++) r_cnt[a] <= w_cnt_nxt[a];
         r_sb_err <= w_err_nxt;
      end
   end

   assign sb_err    = r_sb_err;
   assign iss_ready = (iss_addr == ADDR_W'(ZERO_REG)) || (r_cnt[iss_addr] != c_cnt_max);

   for (genvar i = 0; i < NRD; i++) begin : g_stall
      logic [ADDR_W-1:0] w_ra;
      logic [CNT_W-1:0]  w_c;
      assign w_ra = rd_addr[i*ADDR_W +: ADDR_W];
      assign w_c  = r_cnt[w_ra];
      // A count of one being written this cycle is served by the bypass path.
      assign rd_stall[i] = rd_en[i] && (w_ra != ADDR_W'(ZERO_REG)) &&
                           ((w_c > CNT_W'(1)) || ((w_c == CNT_W'(1)) && !w_wr_hit[w_ra]));
   end

endmodule
`default_nettype wire

// File: rtl/gpr_file_mp.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module : gpr_file_mp                                                    |
// | NRD-read / NWR-write register file, write-through bypass, optional      |
// | outstanding-write scoreboard enabled by GPR_SCOREBOARD_EN.              |
// | Rev    : 1.0  initial release                                           |
// +-------------------------------------------------------------------------+
module gpr_file_mp
   import gpr_pkg::*;
#(
   parameter int DATA_W = GPR_DATA_W,
   parameter int ADDR_W = GPR_ADDR_W,
   parameter int NRD    = 2,
   parameter int NWR    = 2,
   parameter int CNT_W  = 2
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NRD-1:0]        rd_en,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   output logic [NRD*DATA_W-1:0] rd_data,
   output logic [NRD-1:0]        rd_stall,
   input  logic [NWR-1:0]        wr_en,
   input  logic [NWR*ADDR_W-1:0] wr_addr,
   input  logic [NWR*DATA_W-1:0] wr_data,
   input  logic                  iss_valid,
   input  logic [ADDR_W-1:0]     iss_addr,
   output logic                  iss_ready,
   output logic                  sb_err
);

   localparam int c_depth = 2**ADDR_W;

   logic [DATA_W-1:0]                  r_mem [c_depth];
   logic [c_depth-1:0]                 w_wr_hit;
   logic [c_depth-1:0][WR_IDX_W-1:0]   w_wr_idx;

   // Entry 0 is never selected, so it keeps its reset value of zero.
   always_comb begin : p_wr_sel
      logic [MAX_WR-1:0] v_match;
      int                v_win;
      v_match  = '0;
      v_win    = -1;
      w_wr_hit = '0;
      w_wr_idx = '0;
      for (int a = 1; a < c_depth; a++) begin
         v_match = '0;
         for (int p = 0; p < NWR; p++)
            v_match[p] = wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(a));
         v_win       = wr_winner(v_match);
         w_wr_hit[a] = reset && (v_win >= 0);
         w_wr_idx[a] = WR_IDX_W'(v_win);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int a = 0; a < c_depth; a++) r_mem[a] <= '0;
      end else begin
         for (int a = 0; a < c_depth; a++)
            if (w_wr_hit[a]) r_mem[a] <= wr_data[w_wr_idx[a]*DATA_W +: DATA_W];
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      assign w_ra = rd_addr[i*ADDR_W +: ADDR_W];
      assign rd_data[i*DATA_W +: DATA_W] =
         (w_ra == ADDR_W'(ZERO_REG)) ? '0 :
         w_wr_hit[w_ra]              ? wr_data[w_wr_idx[w_ra]*DATA_W +: DATA_W] :
                                       r_mem[w_ra];
   end

`ifdef GPR_SCOREBOARD_EN
   gpr_scoreboard #(
      .ADDR_W (ADDR_W),
      .NRD    (NRD),
      .NWR    (NWR),
      .CNT_W  (CNT_W)
   ) u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .iss_valid (iss_valid),
      .iss_addr  (iss_addr),
      .iss_ready (iss_ready),
      .rd_stall  (rd_stall),
      .sb_err    (sb_err)
   );
`else
   localparam int c_unused_cnt_w = CNT_W;
   logic w_unused_sb;
   assign w_unused_sb = ^{rd_en, iss_valid, iss_addr};
   assign rd_stall    = '0;
   assign iss_ready   = 1'b1;
   assign sb_err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gpr_file_mp.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module : tb_gpr_file_mp                                                 |
// | Self-checking bench for gpr_file_mp against a behavioural model.        |
// | Rev    : 1.0  initial release                                           |
// +-------------------------------------------------------------------------+
module tb_gpr_file_mp;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NRD    = 2;
   localparam int NWR    = 2;
   localparam int CNT_W  = 2;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef GPR_SCOREBOARD_EN
   localparam bit SB = 1'b1;
`else
   localparam bit SB = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NRD-1:0]        rd_en;
   logic [NRD*ADDR_W-1:0] rd_addr;
   logic [NRD*DATA_W-1:0] rd_data;
   logic [NRD-1:0]        rd_stall;
   logic [NWR-1:0]        wr_en;
   logic [NWR*ADDR_W-1:0] wr_addr;
   logic [NWR*DATA_W-1:0] wr_data;
   logic                  iss_valid;
   logic [ADDR_W-1:0]     iss_addr;
   logic                  iss_ready;
   logic                  sb_err;

   gpr_file_mp #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .NWR(NWR), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_stall(rd_stall),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
      .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   logic [DATA_W-1:0] m_mem [DEPTH];
   int                m_cnt [DEPTH];
   bit                m_err = 1'b0;

   initial begin
      for (int a = 0; a < DEPTH; a++) begin
         m_mem[a] = '0;
         m_cnt[a] = 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // A write "happens" to a only while out of reset.
   function automatic bit written(input int a);
      bit w;
      w = 1'b0;
      if (reset)
         for (int p = 0; p < NWR; p++)
            if (wr_en[p] && int'(wr_addr[p*ADDR_W +: ADDR_W]) == a) w = 1'b1;
      return w;
   endfunction

   function automatic logic [DATA_W-1:0] exp_rd(input int i);
      int a;
      logic [DATA_W-1:0] v;
      a = int'(rd_addr[i*ADDR_W +: ADDR_W]);
      if (a == 0) return '0;
      v = m_mem[a];
      if (reset)
         for (int p = 0; p < NWR; p++)
            if (wr_en[p] && int'(wr_addr[p*ADDR_W +: ADDR_W]) == a) v = wr_data[p*DATA_W +: DATA_W];
      return v;
   endfunction

   function automatic bit exp_stall(input int i);
      int a;
      a = int'(rd_addr[i*ADDR_W +: ADDR_W]);
      if (!SB || !rd_en[i] || a == 0) return 1'b0;
      return (m_cnt[a] > 1) || (m_cnt[a] == 1 && !written(a));
   endfunction

   function automatic bit exp_ready();
      return !SB || (m_cnt[int'(iss_addr)] != CMAX);
   endfunction

   // Reference state update from the behavioural rules.
   always @(posedge clk) begin : p_model
      int nc [DEPTH];
      bit e;
      bit inc, dec, w;
      e = 1'b0;
      if (!reset) begin
         for (int a = 0; a < DEPTH; a++) begin
            m_mem[a] = '0;
            m_cnt[a] = 0;
         end
         m_err = 1'b0;
      end else begin
         nc[0] = 0;
         for (int a = 1; a < DEPTH; a++) begin
            w   = written(a);
            inc = SB && iss_valid && int'(iss_addr) == a && m_cnt[a] != CMAX;
            dec = SB && w && m_cnt[a] != 0;
            if (w && m_cnt[a] == 0) e = 1'b1;
            nc[a] = m_cnt[a] + int'(inc) - int'(dec);
         end
         for (int p = 0; p < NWR; p++)
            if (wr_en[p] && wr_addr[p*ADDR_W +: ADDR_W] != '0)
               m_mem[wr_addr[p*ADDR_W +: ADDR_W]] = wr_data[p*DATA_W +: DATA_W];
         for (int a = 0; a < DEPTH; a++) m_cnt[a] = nc[a];
         m_err = SB && e;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         for (int i = 0; i < NRD; i++) begin
            chk("rd_data", rd_data[i*DATA_W +: DATA_W], exp_rd(i));
            chk("rd_stall", 32'(rd_stall[i]), 32'(exp_stall(i)));
         end
         chk("iss_ready", 32'(iss_ready), 32'(exp_ready()));
         chk("sb_err", 32'(sb_err), 32'(m_err));
      end
   end

   task automatic idle();
      rd_en = '0; rd_addr = '0;
      wr_en = '0; wr_addr = '0; wr_data = '0;
      iss_valid = 1'b0; iss_addr = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr0(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wr_en[0] = 1'b1; wr_addr[ADDR_W-1:0] = a; wr_data[DATA_W-1:0] = d;
   endtask

   initial begin
      idle();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk_on = 1'b1;

      // Reset contents
      for (int a = 0; a < DEPTH; a++) begin
         idle();
         rd_addr = {ADDR_W'(a), ADDR_W'(a)};
         @(negedge clk);
         chk("t1_rd0", rd_data[31:0], 32'h0);
         chk("t1_rd1", rd_data[63:32], 32'h0);
         chk("t1_sb_err", 32'(sb_err), 32'h0);
         tick();
      end

      // Two ports to one address: higher index wins, bypass then stored
      idle();
      wr_en = 2'b11; wr_addr = {5'd5, 5'd5}; wr_data = {32'h5555FFFF, 32'hAAAA0000};
      rd_addr[4:0] = 5'd5;
      @(negedge clk); chk("t2_bypass", rd_data[31:0], 32'h5555FFFF);
      tick();
      idle(); rd_addr[4:0] = 5'd5;
      @(negedge clk); chk("t2_stored", rd_data[31:0], 32'h5555FFFF);
      tick();
      idle(); wr0(5'd0, 32'hDEADBEEF);
      @(negedge clk); chk("t2_zero_byp", rd_data[31:0], 32'h0);
      tick();
      idle();
      @(negedge clk); chk("t2_zero_stored", rd_data[31:0], 32'h0);
      tick();

      // Issue, stall, then writeback covered by bypass
      idle(); iss_valid = 1'b1; iss_addr = 5'd7;
      tick();
      idle(); rd_en = 2'b01; rd_addr[4:0] = 5'd7;
      @(negedge clk); chk("t3_stall", 32'(rd_stall[0]), 32'(SB));
      tick();
      idle(); rd_en = 2'b01; rd_addr[4:0] = 5'd7; wr0(5'd7, 32'h1234);
      @(negedge clk);
      chk("t3_stall_byp", 32'(rd_stall[0]), 32'h0);
      chk("t3_data_byp", rd_data[31:0], 32'h1234);
      tick();
      idle(); rd_en = 2'b01; rd_addr[4:0] = 5'd7; iss_addr = 5'd7;
      @(negedge clk);
      chk("t3_stall_after", 32'(rd_stall[0]), 32'h0);
      chk("t3_ready_after", 32'(iss_ready), 32'h1);
      chk("t3_data_after", rd_data[31:0], 32'h1234);
      tick();

      // Counter saturation, dropped issue, simultaneous issue+write holds
      for (int k = 0; k < 3; k++) begin
         idle(); iss_valid = 1'b1; iss_addr = 5'd9;
         tick();
      end
      idle(); iss_valid = 1'b1; iss_addr = 5'd9;
      @(negedge clk); chk("t4_full", 32'(iss_ready), 32'(!SB));
      tick();
      idle(); iss_addr = 5'd9; wr0(5'd9, 32'h9);
      tick();
      idle(); iss_addr = 5'd9;
      @(negedge clk); chk("t4_ready_at2", 32'(iss_ready), 32'h1);
      iss_valid = 1'b1; wr0(5'd9, 32'h99);
      tick();
      idle(); iss_valid = 1'b1; iss_addr = 5'd9;
      tick();
      idle(); iss_addr = 5'd9; rd_en = 2'b10; rd_addr[9:5] = 5'd9;
      @(negedge clk);
      chk("t4_hold_full", 32'(iss_ready), 32'(!SB));
      chk("t4_stall", 32'(rd_stall[1]), 32'(SB));
      tick();
      for (int k = 0; k < 3; k++) begin
         idle(); wr0(5'd9, 32'(k));
         tick();
      end

      // Writeback with no outstanding issue
      idle(); wr0(5'd3, 32'hCAFE0003);
      @(negedge clk); chk("t5_pre", 32'(sb_err), 32'h0);
      tick();
      idle(); rd_addr[4:0] = 5'd3;
      @(negedge clk);
      chk("t5_err", 32'(sb_err), 32'(SB));
      chk("t5_data", rd_data[31:0], 32'hCAFE0003);
      tick();
      idle();
      @(negedge clk); chk("t5_clear", 32'(sb_err), 32'h0);
      tick();

      // Reset drops an outstanding issue; its writeback then flags an error
      idle(); iss_valid = 1'b1; iss_addr = 5'd4;
      tick();
      idle(); reset = 1'b0;
      tick();
      reset = 1'b1; idle(); wr0(5'd4, 32'h4444);
      tick();
      idle();
      @(negedge clk); chk("t6_reset_err", 32'(sb_err), 32'(SB));
      tick();

      // Randomised traffic on a narrow address window to force collisions
      for (int c = 0; c < 3000; c++) begin
         reset     = ($urandom_range(0, 99) != 0);
         rd_en     = NRD'($urandom_range(0, (1 << NRD) - 1));
         wr_en     = NWR'($urandom_range(0, (1 << NWR) - 1));
         iss_valid = 1'($urandom_range(0, 1));
         iss_addr  = ADDR_W'($urandom_range(0, 7));
         for (int i = 0; i < NRD; i++) rd_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 7));
         for (int p = 0; p < NWR; p++) begin
            wr_addr[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 7));
            wr_data[p*DATA_W +: DATA_W] = DATA_W'($urandom);
         end
         tick();
      end

      reset = 1'b1;
      idle();
      tick();
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
